// File: rtl/kalman_pkg.sv
// Shared definitions for the Kalman measurement path: FSM encoding, width helpers.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package kalman_pkg;

    // Width of the coordinates and measurements exchanged with the kalman block.
    localparam int KALMAN_DISP_WIDTH = 11;
    localparam int KALMAN_MEAS_W     = 2 * KALMAN_DISP_WIDTH;

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_DIVIDE  = 2'd1,
        ST_PRESENT = 2'd2
    } meas_state_e;

    // A sum of up to 2^(2*dw) coordinates, each below 2^dw, fits in 3*dw bits.
    function automatic int acc_w(input int dw);
        return 3 * dw;
    endfunction

    function automatic int cnt_w(input int dw);
        return 2 * dw;
    endfunction

endpackage

// File: rtl/kalman_meas_gen_if.sv
// Pixel-in / measurement-out bundle between classifier, kalman_meas_gen and kalman.
// Latency: none (wiring only).
// Backpressure: measurement side uses valid/ready; pixel side has none.
interface kalman_meas_gen_if
    import kalman_pkg::*;
#(
    parameter int DISP_WIDTH = KALMAN_DISP_WIDTH
);
    logic                  pix_valid;
    logic [DISP_WIDTH-1:0] pix_x;
    logic [DISP_WIDTH-1:0] pix_y;
    logic                  pix_hit;
    logic                  frame_end;
    logic [DISP_WIDTH-1:0] z_x;
    logic [DISP_WIDTH-1:0] z_y;
    logic                  valid;
    logic                  ready;
    logic                  no_object;
    logic                  meas_drop;

    // Measurement generator view.
    modport master (
        input  pix_valid, pix_x, pix_y, pix_hit, frame_end, ready,
        output z_x, z_y, valid, no_object, meas_drop
    );

    // Environment view: classifier and kalman together.
    modport slave (
        output pix_valid, pix_x, pix_y, pix_hit, frame_end, ready,
        input  z_x, z_y, valid, no_object, meas_drop
    );
endinterface

// File: rtl/centroid_div.sv
// Restoring unsigned divider, one quotient bit per cycle, low QUO_W quotient bits out.
// Latency: o_done pulses DVD_W cycles after the i_start edge; i_start restarts at once.
// Backpressure: none; o_quo holds until the next i_start.
module centroid_div #(
    parameter int DVD_W = 33,
    parameter int DVS_W = 22,
    parameter int QUO_W = 11
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             i_start,
    input  logic [DVD_W-1:0] i_dvd,
    input  logic [DVS_W-1:0] i_dvs,
    output logic             o_done,
    output logic [QUO_W-1:0] o_quo
);
    localparam int IT_W = $clog2(DVD_W + 1);

    logic [DVS_W-1:0] r_rem;
    logic [DVD_W-1:0] r_quo;     // dividend shifts out the top, quotient in the bottom
    logic [DVS_W-1:0] r_dvs;
    logic [IT_W-1:0]  r_iter;
    logic             r_done;

    // Remainder never reaches the divisor, so one extra bit covers the shift-in.
    logic [DVS_W:0] w_shift;
    logic [DVS_W:0] w_diff;

    assign w_shift = {r_rem, r_quo[DVD_W-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign o_done  = r_done;
    assign o_quo   = r_quo[QUO_W-1:0];

    // Load on start, then one trial subtraction per cycle until the counter empties.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvs  <= '0;
            r_iter <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem  <= '0;
                r_quo  <= i_dvd;
                r_dvs  <= i_dvs;
                r_iter <= IT_W'(DVD_W);
            end else if (r_iter != '0) begin
                r_iter <= r_iter - IT_W'(1);
                r_rem  <= w_diff[DVS_W] ? w_shift[DVS_W-1:0] : w_diff[DVS_W-1:0];
                r_quo  <= {r_quo[DVD_W-2:0], ~w_diff[DVS_W]};
                if (r_iter == IT_W'(1)) begin
                    r_done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/kalman_meas_gen.sv
// Per-frame centroid of object pixels; KALMAN_MEAS_ROUND_EN selects round-half-up division.
// Latency: valid rises ACC_W+1 cycles after the closing frame_end (ACC_W+2 when rounding).
// Backpressure: valid holds until ready; frames closing while busy are dropped (meas_drop).
module kalman_meas_gen
    import kalman_pkg::*;
#(
    parameter int DISP_WIDTH = 11,
    parameter int MIN_PIXELS = 16,
    parameter int ACC_W      = acc_w(DISP_WIDTH),
    parameter int CNT_W      = cnt_w(DISP_WIDTH)
) (
    input logic               clk,
    input logic               aresetn,
    kalman_meas_gen_if.master bus
);
`ifdef KALMAN_MEAS_ROUND_EN
    localparam int DIV_W = ACC_W + 1;
`else
    localparam int DIV_W = ACC_W;
`endif

    meas_state_e r_state;
    meas_state_e w_state_nxt;

    logic [ACC_W-1:0]      r_sum_x, r_sum_y;
    logic [CNT_W-1:0]      r_cnt;
    logic [DISP_WIDTH-1:0] r_z_x, r_z_y;
    logic                  r_valid, r_no_obj, r_drop;

    logic                  w_hit, w_close;
    logic [ACC_W-1:0]      w_sum_x_fin, w_sum_y_fin;
    logic [CNT_W-1:0]      w_cnt_fin;
    logic [DIV_W-1:0]      w_dvd_x, w_dvd_y;
    logic                  w_start, w_no_obj, w_drop, w_latch;
    logic                  w_done_x, w_done_y, w_div_done;
    logic [DISP_WIDTH-1:0] w_quo_x, w_quo_y;

    assign w_hit   = bus.pix_valid & bus.pix_hit;
    assign w_close = bus.pix_valid & bus.frame_end;

    // Totals including this cycle's pixel, so the frame_end pixel joins its own frame.
    assign w_sum_x_fin = r_sum_x + (w_hit ? ACC_W'(bus.pix_x) : '0);
    assign w_sum_y_fin = r_sum_y + (w_hit ? ACC_W'(bus.pix_y) : '0);
    assign w_cnt_fin   = r_cnt + (w_hit ? CNT_W'(1) : '0);

`ifdef KALMAN_MEAS_ROUND_EN
    assign w_dvd_x = DIV_W'(w_sum_x_fin) + DIV_W'(w_cnt_fin >> 1);
    assign w_dvd_y = DIV_W'(w_sum_y_fin) + DIV_W'(w_cnt_fin >> 1);
`else
    assign w_dvd_x = w_sum_x_fin;
    assign w_dvd_y = w_sum_y_fin;
`endif

    // Accumulate every cycle regardless of state; any frame close restarts from zero.
    always_ff @(posedge clk) begin
        if (!aresetn || w_close) begin
            r_sum_x <= '0;
            r_sum_y <= '0;
            r_cnt   <= '0;
        end else begin
            r_sum_x <= w_sum_x_fin;
            r_sum_y <= w_sum_y_fin;
            r_cnt   <= w_cnt_fin;
        end
    end

    centroid_div #(.DVD_W(DIV_W), .DVS_W(CNT_W), .QUO_W(DISP_WIDTH)) u_div_x (
        .clk(clk), .aresetn(aresetn), .i_start(w_start),
        .i_dvd(w_dvd_x), .i_dvs(w_cnt_fin), .o_done(w_done_x), .o_quo(w_quo_x)
    );

    centroid_div #(.DVD_W(DIV_W), .DVS_W(CNT_W), .QUO_W(DISP_WIDTH)) u_div_y (
        .clk(clk), .aresetn(aresetn), .i_start(w_start),
        .i_dvd(w_dvd_y), .i_dvs(w_cnt_fin), .o_done(w_done_y), .o_quo(w_quo_y)
    );

    // Both dividers start together and take the same number of steps.
    assign w_div_done = w_done_x & w_done_y;

    // State register.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle controls; closes outside ACCUM are always dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_no_obj    = 1'b0;
        w_drop      = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                if (w_close) begin
                    if (w_cnt_fin >= CNT_W'(MIN_PIXELS)) begin
                        w_start     = 1'b1;
                        w_state_nxt = ST_DIVIDE;
                    end else begin
                        w_no_obj = 1'b1;
                    end
                end
            end
            ST_DIVIDE: begin
                w_drop = w_close;
                if (w_div_done) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                w_drop = w_close;
                if (r_valid && bus.ready) begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            default: w_state_nxt = ST_ACCUM;
        endcase
    end

    // Registered outputs; valid follows the next state so ready never reaches it combinationally.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_valid  <= 1'b0;
            r_no_obj <= 1'b0;
            r_drop   <= 1'b0;
            r_z_x    <= '0;
            r_z_y    <= '0;
        end else begin
            r_valid  <= (w_state_nxt == ST_PRESENT);
            r_no_obj <= w_no_obj;
            r_drop   <= w_drop;
            if (w_latch) begin
                r_z_x <= w_quo_x;
                r_z_y <= w_quo_y;
            end
        end
    end

    assign bus.valid     = r_valid;
    assign bus.no_object = r_no_obj;
    assign bus.meas_drop = r_drop;
    assign bus.z_x       = r_z_x;
    assign bus.z_y       = r_z_y;
endmodule

// File: tb/tb_kalman_meas_gen.sv
// Self-checking bench for kalman_meas_gen with a frame-level centroid model.
// Latency: checks valid at ACC_W+1 (ACC_W+2 with KALMAN_MEAS_ROUND_EN) after frame close.
// Backpressure: exercises held ready, busy drops and transfer-coincident drops.
module tb_kalman_meas_gen;
    localparam int DW    = 11;
    localparam int MINP  = 4;
    localparam int ACC_W = 3 * DW;
`ifdef KALMAN_MEAS_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif
    localparam int LAT = ACC_W + 1 + RND;

    logic clk = 1'b0;
    logic aresetn;
    always #5 clk = ~clk;

    kalman_meas_gen_if #(.DISP_WIDTH(DW)) bus ();

    kalman_meas_gen #(.DISP_WIDTH(DW), .MIN_PIXELS(MINP)) dut (
        .clk(clk), .aresetn(aresetn), .bus(bus)
    );

    int unsigned chk_cnt  = 0;
    int unsigned pass_cnt = 0;

    // Frame model: running sums of hit pixels, result computed when the frame closes.
    longint m_sx, m_sy, m_n;
    longint m_ex, m_ey, m_close_n;

    task automatic model_clear();
        m_sx = 0; m_sy = 0; m_n = 0;
    endtask

    task automatic idle_inputs();
        bus.pix_valid = 1'b0; bus.pix_hit = 1'b0; bus.frame_end = 1'b0;
        bus.pix_x = '0; bus.pix_y = '0;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    // One pixel cycle; returns 1 ns after the edge that sampled it.
    task automatic px(input int x, input int y, input bit hit, input bit fe);
        bus.pix_valid = 1'b1; bus.pix_hit = hit; bus.frame_end = fe;
        bus.pix_x = DW'(x); bus.pix_y = DW'(y);
        if (hit) begin m_sx += x; m_sy += y; m_n++; end
        if (fe) begin
            m_close_n = m_n;
            if (m_n > 0) begin
                m_ex = (m_sx + RND * (m_n / 2)) / m_n;
                m_ey = (m_sy + RND * (m_n / 2)) / m_n;
            end
            model_clear();
        end
        cyc();
        idle_inputs();
    endtask

    // A cycle the DUT must ignore: non-hit pixel, or invalid cycle with hit/frame_end set.
    task automatic noise();
        bus.pix_valid = 1'($urandom_range(0, 1));
        bus.pix_hit   = ~bus.pix_valid;
        bus.frame_end = ~bus.pix_valid;
        bus.pix_x = DW'($urandom_range(0, 2047));
        bus.pix_y = DW'($urandom_range(0, 2047));
        cyc();
        idle_inputs();
    endtask

    task automatic send_frame(input int nhits);
        for (int i = 0; i < nhits; i++) begin
            if ($urandom_range(0, 2) == 0) noise();
            px($urandom_range(0, 2047), $urandom_range(0, 2047), 1'b1, i == nhits - 1);
        end
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (bus.valid !== 1'b1 && k < 300) begin
            cyc();
            k++;
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (2) cyc();
        chk_cnt += 5;
        if (bus.valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.valid);
        else pass_cnt++;
        if (bus.no_object !== 1'b0) $display("FAIL reset_no_object: got %b expected 0", bus.no_object);
        else pass_cnt++;
        if (bus.meas_drop !== 1'b0) $display("FAIL reset_meas_drop: got %b expected 0", bus.meas_drop);
        else pass_cnt++;
        if (bus.z_x !== 11'd0) $display("FAIL reset_z_x: got %0d expected 0", bus.z_x);
        else pass_cnt++;
        if (bus.z_y !== 11'd0) $display("FAIL reset_z_y: got %0d expected 0", bus.z_y);
        else pass_cnt++;
        aresetn = 1'b1;
        model_clear();
        cyc();
    endtask

    task automatic test_basic();
        int k;
        bus.ready = 1'b1;
        px(10, 20, 1, 0); px(12, 20, 1, 0); px(10, 22, 1, 0); px(12, 22, 1, 1);
        wait_valid(k);
        chk_cnt += 4;
        if (k != LAT) $display("FAIL basic_latency: got %0d expected %0d", k, LAT);
        else pass_cnt++;
        if (bus.z_x !== DW'(11)) $display("FAIL basic_z_x: got %0d expected 11", bus.z_x);
        else pass_cnt++;
        if (bus.z_y !== DW'(21)) $display("FAIL basic_z_y: got %0d expected 21", bus.z_y);
        else pass_cnt++;
        cyc();
        if (bus.valid !== 1'b0) $display("FAIL basic_one_cycle_valid: got %b expected 0", bus.valid);
        else pass_cnt++;
    endtask

    task automatic test_no_object();
        int k;
        bus.ready = 1'b1;
        px(100, 200, 1, 0); px(300, 400, 1, 0); px(500, 600, 1, 1);
        chk_cnt += 2;
        if (bus.no_object !== 1'b1) $display("FAIL no_object_pulse: got %b expected 1", bus.no_object);
        else pass_cnt++;
        cyc();
        if (bus.no_object !== 1'b0) $display("FAIL no_object_width: got %b expected 0", bus.no_object);
        else pass_cnt++;
        k = 0;
        for (int i = 0; i < LAT + 5; i++) begin
            if (bus.valid === 1'b1) k++;
            cyc();
        end
        chk_cnt++;
        if (k != 0) $display("FAIL no_object_valid: got %0d valid cycles expected 0", k);
        else pass_cnt++;
        send_frame(4);
        wait_valid(k);
        chk_cnt += 2;
        if (bus.z_x !== DW'(m_ex)) $display("FAIL fresh_frame_z_x: got %0d expected %0d", bus.z_x, m_ex);
        else pass_cnt++;
        if (bus.z_y !== DW'(m_ey)) $display("FAIL fresh_frame_z_y: got %0d expected %0d", bus.z_y, m_ey);
        else pass_cnt++;
        cyc();
    endtask

    task automatic test_backpressure();
        int k, bad;
        logic [DW-1:0] hx, hy;
        bus.ready = 1'b0;
        send_frame(9);
        wait_valid(k);
        hx = bus.z_x; hy = bus.z_y;
        chk_cnt += 2;
        if (hx !== DW'(m_ex) || hy !== DW'(m_ey))
            $display("FAIL bp_value: got (%0d,%0d) expected (%0d,%0d)", hx, hy, m_ex, m_ey);
        else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (bus.valid !== 1'b1 || bus.z_x !== hx || bus.z_y !== hy) bad++;
        end
        if (bad != 0) $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
        else pass_cnt++;
        bus.ready = 1'b1;
        cyc();
        chk_cnt += 2;
        if (bus.valid !== 1'b0) $display("FAIL bp_release: got %b expected 0", bus.valid);
        else pass_cnt++;
        if (bus.z_x !== hx) $display("FAIL bp_z_retained: got %0d expected %0d", bus.z_x, hx);
        else pass_cnt++;
    endtask

    task automatic test_busy_drop();
        int k;
        longint e1x, e1y;
        bus.ready = 1'b0;
        send_frame(6);
        e1x = m_ex; e1y = m_ey;
        repeat (5) cyc();
        send_frame(5);
        chk_cnt += 2;
        if (bus.meas_drop !== 1'b1) $display("FAIL drop_divide: got %b expected 1", bus.meas_drop);
        else pass_cnt++;
        cyc();
        if (bus.meas_drop !== 1'b0) $display("FAIL drop_width: got %b expected 0", bus.meas_drop);
        else pass_cnt++;
        wait_valid(k);
        chk_cnt += 2;
        if (bus.z_x !== DW'(e1x)) $display("FAIL drop_intact_z_x: got %0d expected %0d", bus.z_x, e1x);
        else pass_cnt++;
        if (bus.z_y !== DW'(e1y)) $display("FAIL drop_intact_z_y: got %0d expected %0d", bus.z_y, e1y);
        else pass_cnt++;
        repeat (3) cyc();
        bus.ready = 1'b1;
        px(7, 8, 1, 1);
        chk_cnt += 3;
        if (bus.meas_drop !== 1'b1) $display("FAIL drop_at_transfer: got %b expected 1", bus.meas_drop);
        else pass_cnt++;
        if (bus.valid !== 1'b0) $display("FAIL transfer_with_close: got %b expected 0", bus.valid);
        else pass_cnt++;
        if (bus.no_object !== 1'b0) $display("FAIL drop_not_no_object: got %b expected 0", bus.no_object);
        else pass_cnt++;
        cyc();
    endtask

    task automatic test_round();
        int k;
        bus.ready = 1'b1;
        px(0, 0, 1, 0); px(1, 0, 1, 0); px(1, 1, 1, 0); px(1, 1, 1, 1);
        wait_valid(k);
        chk_cnt += 3;
        if (k != LAT) $display("FAIL round_latency: got %0d expected %0d", k, LAT);
        else pass_cnt++;
        if (bus.z_x !== DW'(RND)) $display("FAIL round_z_x: got %0d expected %0d", bus.z_x, RND);
        else pass_cnt++;
        if (bus.z_y !== DW'(RND)) $display("FAIL round_z_y: got %0d expected %0d", bus.z_y, RND);
        else pass_cnt++;
        cyc();
    endtask

    task automatic test_reset_mid();
        int k;
        bus.ready = 1'b1;
        send_frame(8);
        repeat (10) cyc();
        aresetn = 1'b0;
        cyc();
        aresetn = 1'b1;
        model_clear();
        chk_cnt += 2;
        if (bus.z_x !== 11'd0 || bus.z_y !== 11'd0)
            $display("FAIL midreset_z: got (%0d,%0d) expected (0,0)", bus.z_x, bus.z_y);
        else pass_cnt++;
        if (bus.valid !== 1'b0 || bus.no_object !== 1'b0 || bus.meas_drop !== 1'b0)
            $display("FAIL midreset_flags: got %b%b%b expected 000", bus.valid, bus.no_object, bus.meas_drop);
        else pass_cnt++;
        k = 0;
        for (int i = 0; i < LAT + 10; i++) begin
            cyc();
            if (bus.valid === 1'b1) k++;
        end
        chk_cnt++;
        if (k != 0) $display("FAIL midreset_no_valid: got %0d valid cycles expected 0", k);
        else pass_cnt++;
        send_frame(7);
        wait_valid(k);
        chk_cnt += 2;
        if (k != LAT) $display("FAIL midreset_latency: got %0d expected %0d", k, LAT);
        else pass_cnt++;
        if (bus.z_x !== DW'(m_ex) || bus.z_y !== DW'(m_ey))
            $display("FAIL midreset_z_next: got (%0d,%0d) expected (%0d,%0d)", bus.z_x, bus.z_y, m_ex, m_ey);
        else pass_cnt++;
        cyc();
    endtask

    task automatic test_back_to_back();
        int k, n;
        for (int f = 0; f < 10; f++) begin
            n = $urandom_range(1, 20);
            bus.ready = 1'($urandom_range(0, 1));
            send_frame(n);
            if (n < MINP) begin
                chk_cnt++;
                if (bus.no_object !== 1'b1) $display("FAIL b2b_no_object: frame %0d got %b expected 1", f, bus.no_object);
                else pass_cnt++;
                cyc();
            end else begin
                wait_valid(k);
                chk_cnt += 2;
                if (k != LAT) $display("FAIL b2b_latency: frame %0d got %0d expected %0d", f, k, LAT);
                else pass_cnt++;
                if (bus.z_x !== DW'(m_ex) || bus.z_y !== DW'(m_ey))
                    $display("FAIL b2b_z: frame %0d got (%0d,%0d) expected (%0d,%0d)", f, bus.z_x, bus.z_y, m_ex, m_ey);
                else pass_cnt++;
                if (bus.ready !== 1'b1) begin
                    repeat ($urandom_range(1, 8)) cyc();
                    bus.ready = 1'b1;
                end
                cyc();
                chk_cnt++;
                if (bus.valid !== 1'b0) $display("FAIL b2b_transfer: frame %0d got %b expected 0", f, bus.valid);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        idle_inputs();
        bus.ready = 1'b0;
        aresetn = 1'b0;
        model_clear();
        test_reset();
        test_basic();
        test_no_object();
        test_backpressure();
        test_busy_drop();
        test_round();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
